// File: rtl/mux_key_pkg.sv
// mux_key_pkg
//   Shared constants and a small helper for the mux_key lookup slice.
//   Holds the default geometry of the key/data table and the width of a
//   single packed key/data pair. No ports.
package mux_key_pkg;

    localparam int MUX_KEY_NR_KEY_DEF   = 32'sd2;
    localparam int MUX_KEY_KEY_LEN_DEF  = 32'sd1;
    localparam int MUX_KEY_DATA_LEN_DEF = 32'sd1;

    // Width of one table entry: key field sits above the data field.
    function automatic int pair_width(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

endpackage

// File: rtl/mux_key_lookup.sv
// mux_key_lookup
//   Purely combinational priority key match over a packed key/data table.
//   Ports:
//     key         [KEY_LEN-1:0]                   lookup key
//     lut         [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] packed pairs, pair i at
//                                                 [i*PAIR_W +: PAIR_W],
//                                                 key in the upper bits
//     default_val [DATA_LEN-1:0]                  no-match value (HAS_DEFAULT=1)
//     out         [DATA_LEN-1:0]                  data of lowest matching pair
//     hit                                         any pair matched
module mux_key_lookup
    import mux_key_pkg::*;
#(
    parameter int NR_KEY      = MUX_KEY_NR_KEY_DEF,
    parameter int KEY_LEN     = MUX_KEY_KEY_LEN_DEF,
    parameter int DATA_LEN    = MUX_KEY_DATA_LEN_DEF,
    parameter int HAS_DEFAULT = 32'sd0
) (
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    input  logic [DATA_LEN-1:0]                  default_val,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit
);

    localparam int PAIR_W = pair_width(KEY_LEN, DATA_LEN);

    logic [NR_KEY-1:0]   match_s;
    logic [DATA_LEN-1:0] data_s [NR_KEY];
    logic [DATA_LEN-1:0] no_match_s;
    logic [DATA_LEN-1:0] sel_data_s;
    logic                hit_s;

    // Per-pair decode: unsigned equality of the key field, data field slice.
    for (genvar i = 0; i < NR_KEY; i++) begin : g_pair
        assign match_s[i] = (lut[i*PAIR_W + DATA_LEN +: KEY_LEN] == key);
        assign data_s[i]  = lut[i*PAIR_W +: DATA_LEN];
    end

    assign no_match_s = (HAS_DEFAULT != 32'sd0) ? default_val : {DATA_LEN{1'b0}};

    // Priority select: walk from the highest index down so that the lowest
    // matching index is the last writer and therefore wins on duplicates.
    always_comb begin
        sel_data_s = no_match_s;
        hit_s      = |match_s;
        for (int i = NR_KEY - 32'sd1; i >= 32'sd0; i--) begin
            sel_data_s = match_s[i] ? data_s[i] : sel_data_s;
        end
    end

    assign out = sel_data_s;
    assign hit = hit_s;

endmodule

// File: rtl/mux_key.sv
// mux_key
//   Keyed lookup multiplexer with a combinational result and an enabled
//   register stage holding a copy of it.
//   Ports:
//     clk, rst_n   clock (rising edge) and asynchronous active-low reset
//     key          [KEY_LEN-1:0] lookup key
//     lut          packed key/data table, pair 0 in the lowest bits
//     default_val  [DATA_LEN-1:0] no-match value when HAS_DEFAULT=1
//     en           capture enable for out_q / hit_q
//     out, hit     combinational lookup result (not affected by reset)
//     out_q, hit_q registered copies, cleared by reset, held while en=0
module mux_key
    import mux_key_pkg::*;
#(
    parameter int NR_KEY      = MUX_KEY_NR_KEY_DEF,
    parameter int KEY_LEN     = MUX_KEY_KEY_LEN_DEF,
    parameter int DATA_LEN    = MUX_KEY_DATA_LEN_DEF,
    parameter int HAS_DEFAULT = 32'sd0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    input  logic [DATA_LEN-1:0]                  default_val,
    input  logic                                 en,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit,
    output logic [DATA_LEN-1:0]                  out_q,
    output logic                                 hit_q
);

    logic [DATA_LEN-1:0] look_out_s;
    logic                look_hit_s;
    logic [DATA_LEN-1:0] out_q_r;
    logic                hit_q_r;

    mux_key_lookup #(
        .NR_KEY      (NR_KEY),
        .KEY_LEN     (KEY_LEN),
        .DATA_LEN    (DATA_LEN),
        .HAS_DEFAULT (HAS_DEFAULT)
    ) u_lookup (
        .key         (key),
        .lut         (lut),
        .default_val (default_val),
        .out         (look_out_s),
        .hit         (look_hit_s)
    );

    // Capture stage: load the live lookup when enabled, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_r <= {DATA_LEN{1'b0}};
            hit_q_r <= 1'b0;
        end else if (en) begin
            out_q_r <= look_out_s;
            hit_q_r <= look_hit_s;
        end else begin
            out_q_r <= out_q_r;
            hit_q_r <= hit_q_r;
        end
    end

    assign out   = look_out_s;
    assign hit   = look_hit_s;
    assign out_q = out_q_r;
    assign hit_q = hit_q_r;

endmodule

// File: tb/tb_mux_key.sv
// tb_mux_key
//   Scoreboard bench for mux_key. Three instances: the 2x1x1 table (A),
//   a 4x2x8 table without default (B) and the same table with a default
//   value (C). Stimulus pushes hand-computed expectations into a queue; a
//   separate monitor pops and compares them on the falling clock edge.
module tb_mux_key;

    // Signal selectors used by the scoreboard entries.
    localparam logic [2:0] S_A_OUT   = 3'd0;
    localparam logic [2:0] S_A_HIT   = 3'd1;
    localparam logic [2:0] S_B_OUT   = 3'd2;
    localparam logic [2:0] S_B_HIT   = 3'd3;
    localparam logic [2:0] S_B_OUT_Q = 3'd4;
    localparam logic [2:0] S_B_HIT_Q = 3'd5;
    localparam logic [2:0] S_C_OUT   = 3'd6;
    localparam logic [2:0] S_C_HIT   = 3'd7;

    // Table with keys 0,1,2 (data 11/22/33) and a duplicate key 0 at pair 3.
    localparam logic [39:0] LUT1 = {2'd0, 8'h44, 2'd2, 8'h33, 2'd1, 8'h22, 2'd0, 8'h11};
    // Duplicate key 1 at pair 0 (5A) and pair 2 (C3).
    localparam logic [39:0] LUT2 = {2'd3, 8'h77, 2'd1, 8'hC3, 2'd2, 8'h99, 2'd1, 8'h5A};

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        en_a;
    logic        key_a;
    logic [3:0]  lut_a;
    logic        dv_a;
    logic        out_a, hit_a, out_q_a, hit_q_a;
    logic [1:0]  key_b;
    logic [39:0] lut_b;
    logic [7:0]  dv_b;
    logic [7:0]  out_b, out_q_b, out_c, out_q_c;
    logic        hit_b, hit_q_b, hit_c, hit_q_c;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_pushed = 0;
    bit   stim_done = 1'b0;

    mux_key #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(1), .HAS_DEFAULT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .key(key_a), .lut(lut_a), .default_val(dv_a),
        .en(en_a), .out(out_a), .hit(hit_a), .out_q(out_q_a), .hit_q(hit_q_a)
    );

    mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .key(key_b), .lut(lut_b), .default_val(dv_b),
        .en(en), .out(out_b), .hit(hit_b), .out_q(out_q_b), .hit_q(hit_q_b)
    );

    mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .key(key_b), .lut(lut_b), .default_val(dv_b),
        .en(en), .out(out_c), .hit(hit_c), .out_q(out_q_c), .hit_q(hit_q_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string sel_name(input logic [2:0] sel);
        case (sel)
            S_A_OUT:   return "a.out";
            S_A_HIT:   return "a.hit";
            S_B_OUT:   return "b.out";
            S_B_HIT:   return "b.hit";
            S_B_OUT_Q: return "b.out_q";
            S_B_HIT_Q: return "b.hit_q";
            S_C_OUT:   return "c.out";
            default:   return "c.hit";
        endcase
    endfunction

    function automatic logic [7:0] pick(input logic [2:0] sel);
        case (sel)
            S_A_OUT:   return {7'd0, out_a};
            S_A_HIT:   return {7'd0, hit_a};
            S_B_OUT:   return out_b;
            S_B_HIT:   return {7'd0, hit_b};
            S_B_OUT_Q: return out_q_b;
            S_B_HIT_Q: return {7'd0, hit_q_b};
            S_C_OUT:   return out_c;
            default:   return {7'd0, hit_c};
        endcase
    endfunction

    task automatic expect_v(input logic [2:0] sel, input logic [7:0] val);
        exp_t e;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Expect the same combinational result on B and C (a key that hits).
    task automatic expect_bc(input logic [7:0] val);
        expect_v(S_B_OUT, val);
        expect_v(S_B_HIT, 8'd1);
        expect_v(S_C_OUT, val);
        expect_v(S_C_HIT, 8'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t       item;
        logic [7:0] actual;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                item   = exp_q.pop_front();
                actual = pick(item.sel);
                n_cmp++;
                if (actual !== item.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h (t=%0t)",
                             sel_name(item.sel), actual, item.val, $time);
                end
            end
            if (stim_done) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        logic ab [2];
        rst_n = 1'b0;
        en    = 1'b0;
        en_a  = 1'b0;
        key_a = 1'b0;
        lut_a = 4'd0;
        dv_a  = 1'b0;
        key_b = 2'd0;
        lut_b = LUT1;
        dv_b  = 8'hAA;
        step();

        // Reset state, and combinational path unaffected by reset.
        key_b = 2'd2;
        expect_v(S_B_OUT_Q, 8'h00);
        expect_v(S_B_HIT_Q, 8'h00);
        expect_bc(8'h33);
        step();

        // A: lut = {0, a, 1, b}; key 0 -> a, key 1 -> b.
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                ab[0] = a[0];
                ab[1] = b[0];
                lut_a = {1'b0, ab[0], 1'b1, ab[1]};
                key_a = 1'b0;
                expect_v(S_A_OUT, {7'd0, ab[0]});
                expect_v(S_A_HIT, 8'd1);
                step();
                key_a = 1'b1;
                expect_v(S_A_OUT, {7'd0, ab[1]});
                expect_v(S_A_HIT, 8'd1);
                step();
            end
        end

        // B/C with LUT1: key 0 wins over the duplicate at pair 3.
        key_b = 2'd0; expect_bc(8'h11); step();
        key_b = 2'd1; expect_bc(8'h22); step();
        key_b = 2'd2; expect_bc(8'h33); step();
        // Absent key: zero without default, default_val with default.
        key_b = 2'd3;
        expect_v(S_B_OUT, 8'h00);
        expect_v(S_B_HIT, 8'h00);
        expect_v(S_C_OUT, 8'hAA);
        expect_v(S_C_HIT, 8'h00);
        step();
        dv_b = 8'h5C;
        expect_v(S_B_OUT, 8'h00);
        expect_v(S_B_HIT, 8'h00);
        expect_v(S_C_OUT, 8'h5C);
        expect_v(S_C_HIT, 8'h00);
        step();

        // LUT2: duplicate key 1 -> pair 0 data 5A.
        lut_b = LUT2;
        key_b = 2'd1; expect_bc(8'h5A); step();
        key_b = 2'd3; expect_bc(8'h77); step();
        key_b = 2'd2; expect_bc(8'h99); step();

        // Registered path: capture 33.
        lut_b = LUT1;
        rst_n = 1'b1;
        en    = 1'b1;
        key_b = 2'd2;
        step();
        n_cmp++;
        if (out_q_b !== 8'h33) begin
            n_bad++;
            $display("FAIL b.out_q after capture: got %h, expected 33 (t=%0t)", out_q_b, $time);
        end
        n_cmp++;
        if (hit_q_b !== 1'b1) begin
            n_bad++;
            $display("FAIL b.hit_q after capture: got %b, expected 1 (t=%0t)", hit_q_b, $time);
        end
        expect_v(S_B_OUT_Q, 8'h33);
        expect_v(S_B_HIT_Q, 8'h01);
        // Hold with en=0 while the combinational output follows the key.
        en    = 1'b0;
        key_b = 2'd3;
        expect_v(S_B_OUT, 8'h00);
        expect_v(S_B_HIT, 8'h00);
        expect_v(S_B_OUT_Q, 8'h33);
        expect_v(S_B_HIT_Q, 8'h01);
        step();
        expect_v(S_B_OUT_Q, 8'h33);
        expect_v(S_B_HIT_Q, 8'h01);
        step();

        // Reset between edges clears the registers immediately.
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_q_b !== 8'h00) begin
            n_bad++;
            $display("FAIL b.out_q in reset: got %h, expected 00 (t=%0t)", out_q_b, $time);
        end
        n_cmp++;
        if (hit_q_b !== 1'b0) begin
            n_bad++;
            $display("FAIL b.hit_q in reset: got %b, expected 0 (t=%0t)", hit_q_b, $time);
        end
        expect_v(S_B_OUT_Q, 8'h00);
        expect_v(S_B_HIT_Q, 8'h00);
        step();

        // Release with en=1: nothing loads until the next rising edge.
        rst_n = 1'b1;
        en    = 1'b1;
        key_b = 2'd1;
        expect_v(S_B_OUT_Q, 8'h00);
        expect_v(S_B_HIT_Q, 8'h00);
        step();
        expect_v(S_B_OUT_Q, 8'h22);
        expect_v(S_B_HIT_Q, 8'h01);
        // Capturing a miss loads zero and hit_q=0.
        key_b = 2'd3;
        step();
        expect_v(S_B_OUT_Q, 8'h00);
        expect_v(S_B_HIT_Q, 8'h00);
        step();

        stim_done = 1'b1;
    end

endmodule
